lane_hit_judge: RTL and testbench

Per-lane judge for the falling-block piano game. It watches one lane's falling block position (`block_h`) together with that lane's player key, and decides per block: PERFECT hit, GOOD hit, or MISS. It keeps the lane's score, current combo and best combo. It sits downstream of the lane's block generator, in the same `clk` domain, and feeds the score/display logic.

---
 rtl/lane_hit_judge.sv | 197 +++++++++++++++++++
 tb/tb_lane_hit_judge.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lane_hit_judge.sv
// Per-lane hit judge: grades each falling block PERFECT/GOOD/MISS and tracks score, combo and best combo.
// Latency: key rise to hit/grade/score is 3 clk edges; a miss is flagged on the edge block_h reaches 720.
// Backpressure: none; stop_or_endgame freezes judging and drops presses, the synchronizer and prev_h keep running.
module lane_hit_judge #(
    parameter logic [9:0]  PERF_LO   = 10'd660,
    parameter logic [9:0]  PERF_HI   = 10'd689,
    parameter logic [9:0]  GOOD_LO   = 10'd630,
    parameter logic [13:0] SCORE_MAX = 14'd9999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        restart,
    input  logic        stop_or_endgame,
    input  logic [9:0]  block_h,
    input  logic        key,
    output logic        hit,
    output logic        miss,
    output logic [1:0]  grade,
    output logic [13:0] score,
    output logic [7:0]  combo,
    output logic [7:0]  max_combo
);

    localparam logic [9:0] NO_BLOCK = 10'd720;
    localparam logic [9:0] LAST_ROW = 10'd719;

    localparam logic [1:0] GRADE_GOOD = 2'b01;
    localparam logic [1:0] GRADE_PERF = 2'b10;
    localparam logic [1:0] GRADE_MISS = 2'b11;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_FALLING = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t      state;
    state_t      state_nxt;

    logic        key_s1;
    logic        key_s2;
    logic        key_s3;
    logic        press;

    logic [9:0]  prev_h;
    logic        nb;

    logic        in_perf;
    logic        in_good;
    logic        early;
    logic [1:0]  pts;
    logic [14:0] score_sum;
    logic [13:0] score_sat;
    logic [7:0]  combo_inc;

    logic        hit_nxt;
    logic        miss_nxt;
    logic [1:0]  grade_nxt;
    logic [13:0] score_nxt;
    logic [7:0]  combo_nxt;
    logic [7:0]  max_combo_nxt;

    // Two-flop synchronizer on the raw key plus one delay flop for rising-edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1 <= 1'b0;
            key_s2 <= 1'b0;
            key_s3 <= 1'b0;
        end else if (restart) begin
            key_s1 <= 1'b0;
            key_s2 <= 1'b0;
            key_s3 <= 1'b0;
        end else begin
            key_s1 <= key;
            key_s2 <= key_s1;
            key_s3 <= key_s2;
        end
    end

    assign press = key_s2 & ~key_s3;

    // Previous block position; a drop in block_h marks a freshly spawned block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_h <= NO_BLOCK;
        end else if (restart) begin
            prev_h <= NO_BLOCK;
        end else begin
            prev_h <= block_h;
        end
    end

    assign nb        = (block_h < prev_h);
    assign in_perf   = (block_h >= PERF_LO) && (block_h <= PERF_HI);
    assign in_good   = (block_h >= GOOD_LO) && (block_h <= LAST_ROW);
    assign early     = (block_h < GOOD_LO);
    assign pts       = in_perf ? 2'd2 : 2'd1;
    assign score_sum = {1'b0, score} + {13'd0, pts};
    assign score_sat = (score_sum > {1'b0, SCORE_MAX}) ? SCORE_MAX : score_sum[13:0];
    assign combo_inc = (combo == 8'hFF) ? 8'hFF : combo + 8'd1;

    // Judge state machine: next state and next values of all scoring outputs.
    always_comb begin
        state_nxt     = state;
        hit_nxt       = 1'b0;
        miss_nxt      = 1'b0;
        grade_nxt     = grade;
        score_nxt     = score;
        combo_nxt     = combo;
        max_combo_nxt = max_combo;
        if (!stop_or_endgame) begin
            unique case (state)
                ST_EMPTY: begin
                    if (nb) begin
                        state_nxt = ST_FALLING;
                    end else if (press) begin
                        combo_nxt = 8'd0;
                    end
                end
                ST_FALLING: begin
                    if (nb) begin
                        // Old block scrolled away unjudged; the new block takes its place.
                        miss_nxt  = 1'b1;
                        grade_nxt = GRADE_MISS;
                        combo_nxt = 8'd0;
                    end else if (press && in_good) begin
                        hit_nxt   = 1'b1;
                        grade_nxt = in_perf ? GRADE_PERF : GRADE_GOOD;
                        score_nxt = score_sat;
                        combo_nxt = combo_inc;
                        if (combo_inc > max_combo) begin
                            max_combo_nxt = combo_inc;
                        end
                        state_nxt = ST_DONE;
                    end else if (press && early) begin
                        combo_nxt = 8'd0;
                    end else if (block_h == NO_BLOCK) begin
                        miss_nxt  = 1'b1;
                        grade_nxt = GRADE_MISS;
                        combo_nxt = 8'd0;
                        state_nxt = ST_EMPTY;
                    end
                end
                ST_DONE: begin
                    if (nb) begin
                        state_nxt = ST_FALLING;
                    end else if (block_h == NO_BLOCK) begin
                        state_nxt = ST_EMPTY;
                    end else if (press) begin
                        combo_nxt = 8'd0;
                    end
                end
                default: begin
                    state_nxt = ST_EMPTY;
                end
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else if (restart) begin
            state <= ST_EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered judgement outputs and score keeping.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hit       <= 1'b0;
            miss      <= 1'b0;
            grade     <= 2'b00;
            score     <= 14'd0;
            combo     <= 8'd0;
            max_combo <= 8'd0;
        end else if (restart) begin
            hit       <= 1'b0;
            miss      <= 1'b0;
            grade     <= 2'b00;
            score     <= 14'd0;
            combo     <= 8'd0;
            max_combo <= 8'd0;
        end else begin
            hit       <= hit_nxt;
            miss      <= miss_nxt;
            grade     <= grade_nxt;
            score     <= score_nxt;
            combo     <= combo_nxt;
            max_combo <= max_combo_nxt;
        end
    end

endmodule

// File: tb/tb_lane_hit_judge.sv
// Bench for lane_hit_judge: directed game scenarios then random play against a block-level reference model.
// Latency: outputs compared 1 time unit after every rising clk edge.
// Backpressure: none; freeze windows are driven through stop_or_endgame.
module tb_lane_hit_judge;

    logic        clk;
    logic        rst_n;
    logic        restart;
    logic        stop_or_endgame;
    logic [9:0]  block_h;
    logic        key;
    logic        hit;
    logic        miss;
    logic [1:0]  grade;
    logic [13:0] score;
    logic [7:0]  combo;
    logic [7:0]  max_combo;

    lane_hit_judge dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .restart         (restart),
        .stop_or_endgame (stop_or_endgame),
        .block_h         (block_h),
        .key             (key),
        .hit             (hit),
        .miss            (miss),
        .grade           (grade),
        .score           (score),
        .combo           (combo),
        .max_combo       (max_combo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference model: one block on screen is either awaiting judgement or already judged.
    bit m_pending;
    bit m_shown;
    int m_prev;
    bit kq[$];
    int m_hit, m_miss, m_grade, m_score, m_combo, m_max;

    int last_hit_h, last_miss_h, n_hit, n_miss;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pending = 0; m_shown = 0; m_prev = 720;
        kq = '{0, 0, 0};
        m_hit = 0; m_miss = 0; m_grade = 0; m_score = 0; m_combo = 0; m_max = 0;
    endtask

    task automatic model_edge(input int h, input bit k, input bit stp, input bit rs);
        bit p;
        bit fresh;
        int pts;
        m_hit = 0;
        m_miss = 0;
        if (rs) begin
            model_reset();
            return;
        end
        // A press is a key sample two edges ago that was low three edges ago.
        p = kq[1] && !kq[0];
        fresh = h < m_prev;
        m_prev = h;
        kq.push_back(k);
        void'(kq.pop_front());
        if (stp) return;
        if (fresh) begin
            if (m_pending) begin
                m_miss = 1; m_grade = 3; m_combo = 0;
            end
            m_pending = 1;
            m_shown = 0;
        end else if (m_pending) begin
            if (p && h >= 630 && h <= 719) begin
                pts = (h >= 660 && h <= 689) ? 2 : 1;
                m_score = (m_score + pts > 9999) ? 9999 : m_score + pts;
                m_combo = (m_combo >= 255) ? 255 : m_combo + 1;
                if (m_combo > m_max) m_max = m_combo;
                m_hit = 1;
                m_grade = pts;
                m_pending = 0;
                m_shown = 1;
            end else if (p && h < 630) begin
                m_combo = 0;
            end else if (h == 720) begin
                m_miss = 1; m_grade = 3; m_combo = 0;
                m_pending = 0;
            end
        end else if (m_shown && h == 720) begin
            m_shown = 0;
        end else if (p) begin
            m_combo = 0;
        end
    endtask

    task automatic compare();
        chk("hit", hit, m_hit);
        chk("miss", miss, m_miss);
        chk("grade", grade, m_grade);
        chk("score", score, m_score);
        chk("combo", combo, m_combo);
        chk("max_combo", max_combo, m_max);
    endtask

    task automatic cycle(input int h, input bit k, input bit stp, input bit rs);
        block_h = 10'(h);
        key = k;
        stop_or_endgame = stp;
        restart = rs;
        @(posedge clk);
        model_edge(h, k, stp, rs);
        #1;
        compare();
        if (hit === 1'b1) begin last_hit_h = h; n_hit++; end
        if (miss === 1'b1) begin last_miss_h = h; n_miss++; end
    endtask

    // Falling block from 'from' to 'to', key pulses timed so presses land at p1/p2, freeze over [flo,fhi].
    task automatic run_block(input int from, input int to, input int p1, input int p2,
                             input int flo, input int fhi);
        bit k;
        n_hit = 0; n_miss = 0; last_hit_h = -1; last_miss_h = -1;
        for (int h = from; h <= to; h++) begin
            k = (p1 >= 0 && h >= p1 - 2 && h <= p1 + 1) || (p2 >= 0 && h >= p2 - 2 && h <= p2 + 1);
            cycle(h, k, (h >= flo && h <= fhi), 1'b0);
        end
    endtask

    initial begin
        int h;
        bit k, stp;
        rst_n = 1'b0; restart = 1'b0; stop_or_endgame = 1'b0; block_h = 10'd720; key = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_grade", grade, 0);
        chk("rst_score", score, 0);
        compare();
        @(negedge clk);
        rst_n = 1'b1;

        // PERFECT hit at 670.
        cycle(720, 0, 0, 0);
        run_block(120, 720, 670, -1, -1, -1);
        chk("t1_hit_at", last_hit_h, 670);
        chk("t1_grade", grade, 2);
        chk("t1_score", score, 2);
        chk("t1_combo", combo, 1);
        chk("t1_max", max_combo, 1);

        // GOOD hit at 640, then an unpressed block misses at 720.
        cycle(720, 0, 0, 1);
        run_block(120, 720, 640, -1, -1, -1);
        chk("t2_grade_good", grade, 1);
        chk("t2_score_good", score, 1);
        run_block(120, 720, -1, -1, -1, -1);
        chk("t2_miss_cnt", n_miss, 1);
        chk("t2_miss_at", last_miss_h, 720);
        chk("t2_grade_miss", grade, 3);
        chk("t2_combo", combo, 0);
        chk("t2_score_kept", score, 1);

        // Early press at 300 keeps the block alive; press at 665 still hits.
        run_block(120, 720, 300, 665, -1, -1);
        chk("t3_hits", n_hit, 1);
        chk("t3_hit_at", last_hit_h, 665);
        chk("t3_score", score, 3);

        // Block replaced at 500 by a new one at 120; the new one is hit at 680.
        run_block(120, 500, -1, -1, -1, -1);
        run_block(120, 720, 680, -1, -1, -1);
        chk("t4_miss_at", last_miss_h, 120);
        chk("t4_hit_at", last_hit_h, 680);
        chk("t4_score", score, 5);

        // Press inside a freeze window is dropped; a later GOOD press hits.
        run_block(120, 720, 670, 700, 660, 689);
        chk("t5_hits", n_hit, 1);
        chk("t5_hit_at", last_hit_h, 700);
        chk("t5_score", score, 6);

        // Saturation: 5000 PERFECT hits starting from a clean score.
        cycle(720, 0, 0, 1);
        for (int i = 0; i < 5000; i++) begin
            cycle(720, 0, 0, 0);
            cycle(660, 1, 0, 0);
            cycle(661, 1, 0, 0);
            cycle(662, 1, 0, 0);
        end
        chk("t6_score_sat", score, 9999);
        chk("t6_combo_sat", combo, 255);
        chk("t6_max_sat", max_combo, 255);
        cycle(720, 0, 0, 1);
        chk("t6_restart_score", score, 0);
        chk("t6_restart_combo", combo, 0);
        chk("t6_restart_max", max_combo, 0);
        chk("t6_restart_grade", grade, 0);

        // Asynchronous reset in the middle of a falling block.
        run_block(120, 400, -1, -1, -1, -1);
        run_block(620, 670, 668, -1, -1, -1);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("t7_async_score", score, 0);
        chk("t7_async_combo", combo, 0);
        chk("t7_async_max", max_combo, 0);
        compare();
        @(posedge clk);
        #1;
        chk("t7_held_miss", miss, 0);
        compare();
        @(negedge clk);
        rst_n = 1'b1;
        n_miss = 0;
        repeat (5) cycle(720, 0, 0, 0);
        chk("t7_no_miss", n_miss, 0);

        // Random play.
        h = 720; k = 0; stp = 0;
        for (int i = 0; i < 3000; i++) begin
            if (h == 720) begin
                if ($urandom_range(0, 3) == 0) h = $urandom_range(120, 600);
            end else if ($urandom_range(0, 63) == 0) begin
                h = 120;
            end else begin
                h = h + $urandom_range(1, 6);
                if (h > 720) h = 720;
            end
            if ($urandom_range(0, 4) == 0) k = !k;
            if ($urandom_range(0, 39) == 0) stp = !stp;
            cycle(h, k, stp, ($urandom_range(0, 299) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
